mem_arbiter: RTL
================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 64: max cycles a granted transfer waits for m_ack_i before abort.
REQ-002 SHALL have parameter STARVE_MAX, default 4: max consecutive MEM grants while an IF request waits.
REQ-003 SHALL have port clk_i  in  1  single clock; all state updates on rising edge.
REQ-004 SHALL have port rst_i  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port if_req_i  in  1  instruction-fetch request, held until if_ack_o.
REQ-006 SHALL have port if_addr_i  in  32  fetch address.
REQ-007 SHALL have ports if_rdata_o  out  32 and if_ack_o  out  1: fetch data and one-cycle completion pulse.
REQ-008 SHALL have port mem_req_i  in  1  data request (MemRead or MemWrite), held until mem_ack_o.
REQ-009 SHALL have ports mem_we_i  in  1, mem_addr_i  in  32, mem_wdata_i  in  32: write enable, address, store data.
REQ-010 SHALL have ports mem_rdata_o  out  32 and mem_ack_o  out  1: load data and one-cycle completion pulse.
REQ-011 SHALL have ports m_req_o  out  1, m_we_o  out  1, m_addr_o  out  32, m_wdata_o  out  32: shared single-port memory request.
REQ-012 SHALL have ports m_rdata_i  in  32 and m_ack_i  in  1: memory read data and completion, valid same cycle.
REQ-013 SHALL have port stall_o  out  1  pipeline stall while any request is pending.
REQ-014 SHALL have port error_o  out  1  sticky timeout flag.

Function
REQ-015 SHALL implement FSM states IDLE, GNT_IF, GNT_MEM.
REQ-016 IDLE: mem_req_i high and starve count < STARVE_MAX -> GNT_MEM; otherwise if_req_i high -> GNT_IF; otherwise mem_req_i high -> GNT_MEM; neither -> stay IDLE.
REQ-017 On entry to GNT_x SHALL latch the winner's address, we, wdata into output registers; m_req_o high the cycle after the request is sampled (1-cycle grant latency).
REQ-018 GNT_IF SHALL drive m_we_o=0 and m_wdata_o=0.
REQ-019 m_req_o, m_we_o, m_addr_o, m_wdata_o SHALL stay constant throughout a GNT state; changes in requester inputs during the grant are ignored.
REQ-020 m_ack_i in GNT_x SHALL register m_rdata_i into the matching rdata_o, pulse the matching ack_o for exactly 1 cycle on the next cycle, and return to IDLE; m_req_o drops the same cycle ack_o rises.
REQ-021 rdata_o SHALL hold its last value until the next completion for that requester.
REQ-022 m_ack_i in IDLE SHALL be ignored.
REQ-023 Minimum spacing SHALL be one IDLE cycle between consecutive transfers; a requester re-asserting in the ack cycle is sampled in that IDLE cycle.
REQ-024 Starve counter (3 bits min) SHALL increment on each GNT_MEM entry while if_req_i is high, clear on GNT_IF entry or when if_req_i is low in IDLE, and saturate at STARVE_MAX.
REQ-025 Wait counter SHALL clear on GNT entry, increment each GNT cycle without m_ack_i; reaching TIMEOUT-1 with no ack SHALL abort: drop m_req_o, ack requester with rdata_o=0, set error_o, go IDLE.
REQ-026 error_o SHALL stay high until reset; arbitration continues normally after it is set.
REQ-027 m_ack_i in the same cycle as timeout SHALL be treated as normal completion; error_o not set.
REQ-028 A requester dropping its req before ack SHALL NOT cancel the transfer; its ack pulse still issues.
REQ-029 stall_o SHALL be combinational: (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o).

Reset
REQ-030 rst_i high at a clock edge SHALL force IDLE, clear both counters, and drive m_req_o, m_we_o, if_ack_o, mem_ack_o, error_o = 0 and m_addr_o, m_wdata_o, if_rdata_o, mem_rdata_o = 0.
REQ-031 Reset mid-transfer SHALL abandon it with no ack pulse; a later m_ack_i in IDLE is ignored.

Verification
REQ-032 Single fetch: if_req_i=1, if_addr_i=0x100, m_ack_i 3 cycles after m_req_o with m_rdata_i=0xDEADBEEF -> m_addr_o=0x100, m_we_o=0, if_ack_o 1-cycle pulse, if_rdata_o=0xDEADBEEF, stall_o low after ack.
REQ-033 Simultaneous: if_req_i and mem_req_i (we=1, addr=0x40, wdata=0x12345678) same cycle -> MEM granted first with m_we_o=1, m_wdata_o=0x12345678; after mem_ack_o, one IDLE cycle, then IF granted.
REQ-034 Starvation: mem_req_i held continuously with if_req_i high, immediate m_ack_i -> exactly 4 MEM grants then 1 IF grant, pattern repeats.
REQ-035 Timeout: grant MEM load, never assert m_ack_i -> m_req_o high 64 cycles then low, mem_ack_o pulse with mem_rdata_o=0, error_o=1 persisting through a following normal fetch.
REQ-036 Reset mid-grant: rst_i during GNT_IF, then m_ack_i next cycle -> no if_ack_o, all outputs 0, state IDLE, error_o=0.

Source files
------------

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Arbitrates one single-port memory between instruction fetch
//               and data access, with starvation guard and transfer timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int TIMEOUT    = 64,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic [31:0] if_rdata_o,
    output logic        if_ack_o,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        m_req_o,
    output logic        m_we_o,
    output logic [31:0] m_addr_o,
    output logic [31:0] m_wdata_o,
    input  logic [31:0] m_rdata_i,
    input  logic        m_ack_i,
    output logic        stall_o,
    output logic        error_o
);
    localparam int WAIT_W   = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam int STARVE_W = ($clog2(STARVE_MAX + 1) > 3) ? $clog2(STARVE_MAX + 1) : 3;
    localparam logic [WAIT_W-1:0]   c_WAIT_LAST  = WAIT_W'(TIMEOUT - 1);
    localparam logic [STARVE_W-1:0] c_STARVE_LIM = STARVE_W'(STARVE_MAX);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        GNT_IF  = 2'd1,
        GNT_MEM = 2'd2
    } state_t;

    state_t              r_state;
    logic [WAIT_W-1:0]   r_waitCnt;
    logic [STARVE_W-1:0] r_starveCnt;
    logic                w_pickMem;
    logic                w_done;

    // Data wins unless fetch has already been passed over STARVE_MAX times.
    assign w_pickMem = mem_req_i && (!if_req_i || (r_starveCnt < c_STARVE_LIM));
    assign w_done    = m_ack_i || (r_waitCnt == c_WAIT_LAST);
    assign stall_o   = (if_req_i & ~if_ack_o) | (mem_req_i & ~mem_ack_o);

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_waitCnt   <= '0;
            r_starveCnt <= '0;
            m_req_o     <= 1'b0;
            m_we_o      <= 1'b0;
            m_addr_o    <= '0;
            m_wdata_o   <= '0;
            if_ack_o    <= 1'b0;
            mem_ack_o   <= 1'b0;
            if_rdata_o  <= '0;
            mem_rdata_o <= '0;
            error_o     <= 1'b0;
        end else begin
            if_ack_o  <= 1'b0;
            mem_ack_o <= 1'b0;
            case (r_state)
                IDLE: begin
                    r_waitCnt <= '0;
                    if (!if_req_i) begin
                        r_starveCnt <= '0;
                    end
                    if (w_pickMem) begin
                        r_state   <= GNT_MEM;
                        m_req_o   <= 1'b1;
                        m_we_o    <= mem_we_i;
                        m_addr_o  <= mem_addr_i;
                        m_wdata_o <= mem_wdata_i;
                        if (if_req_i && (r_starveCnt < c_STARVE_LIM)) begin
                            r_starveCnt <= r_starveCnt + 1'b1;
                        end
                    end else if (if_req_i) begin
                        r_state     <= GNT_IF;
                        m_req_o     <= 1'b1;
                        m_we_o      <= 1'b0;
                        m_addr_o    <= if_addr_i;
                        m_wdata_o   <= '0;
                        r_starveCnt <= '0;
                    end
                end
                GNT_IF, GNT_MEM: begin
                    if (w_done) begin
                        // An ack on the final wait cycle still counts as a normal completion.
                        r_state <= IDLE;
                        m_req_o <= 1'b0;
                        if (!m_ack_i) begin
                            error_o <= 1'b1;
                        end
                        if (r_state == GNT_IF) begin
                            if_ack_o   <= 1'b1;
                            if_rdata_o <= m_ack_i ? m_rdata_i : 32'h0;
                        end else begin
                            mem_ack_o   <= 1'b1;
                            mem_rdata_o <= m_ack_i ? m_rdata_i : 32'h0;
                        end
                    end else begin
                        r_waitCnt <= r_waitCnt + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    m_req_o <= 1'b0;
                end
            endcase
        end
    end
endmodule
`default_nettype wire
